// File: rtl/ysyx_pkg.sv
// ysyx_pkg: arbiter FSM states, AXI response codes and strobe-to-size decode
package ysyx_pkg;
  typedef enum logic [2:0] {IDLE, I_AR, I_R, D_AR, D_R, D_AW, D_B} arb_state_e;
  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
  function automatic logic [2:0] strb2size(input logic [7:0] s);
    return s == 8'h01 ? 3'd0 : s == 8'h03 ? 3'd1 : s == 8'h0f ? 3'd2 : 3'd3;
  endfunction
endpackage

// File: rtl/ysyx_mem_arb_rr.sv
// ysyx_mem_arb_rr: 2-way alternating picker; req_i/req_d in, last_d (1 = D won last), gnt_i/gnt_d out
module ysyx_mem_arb_rr (
  input  logic req_i,
  input  logic req_d,
  input  logic last_d,
  output logic gnt_i,
  output logic gnt_d
);
  assign gnt_i = req_i & (~req_d | last_d);
  assign gnt_d = req_d & (~req_i | ~last_d);
endmodule

// File: rtl/ysyx_mem_arb.sv
// ysyx_mem_arb: I-refill and D load/store requesters onto one AXI4 master, one outstanding txn, alternating priority, sticky bus_err
module ysyx_mem_arb
  import ysyx_pkg::*;
#(
  parameter int XLEN          = 32,
  parameter int L1I_BURST_LEN = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ifu_arvalid,
  input  logic [XLEN-1:0]   ifu_araddr,
  output logic              ifu_rready,
  output logic [XLEN-1:0]   ifu_rdata,
  output logic              ifu_rvalid,
  output logic              ifu_rlast,
  input  logic              lsu_arvalid,
  input  logic [XLEN-1:0]   lsu_araddr,
  input  logic [7:0]        lsu_rstrb,
  output logic              lsu_rready,
  output logic [XLEN-1:0]   lsu_rdata,
  output logic              lsu_rvalid,
  output logic              lsu_rlast,
  input  logic              lsu_awvalid,
  input  logic [XLEN-1:0]   lsu_awaddr,
  input  logic              lsu_wvalid,
  input  logic [XLEN-1:0]   lsu_wdata,
  input  logic [7:0]        lsu_wstrb,
  output logic              lsu_wready,
  output logic              mem_arvalid,
  input  logic              mem_arready,
  output logic [XLEN-1:0]   mem_araddr,
  output logic [7:0]        mem_arlen,
  output logic [2:0]        mem_arsize,
  input  logic              mem_rvalid,
  output logic              mem_rready,
  input  logic [XLEN-1:0]   mem_rdata,
  input  logic [1:0]        mem_rresp,
  input  logic              mem_rlast,
  output logic              mem_awvalid,
  input  logic              mem_awready,
  output logic [XLEN-1:0]   mem_awaddr,
  output logic [2:0]        mem_awsize,
  output logic              mem_wvalid,
  input  logic              mem_wready,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [XLEN/8-1:0] mem_wstrb,
  output logic              mem_wlast,
  input  logic              mem_bvalid,
  output logic              mem_bready,
  input  logic [1:0]        mem_bresp,
  output logic              bus_err
);
  arb_state_e st_q, st_d;
  logic last_d_q, last_d_d;
  logic [XLEN-1:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [XLEN/8-1:0] wstrb_q, wstrb_d;
  logic [7:0] len_q, len_d;
  logic [2:0] size_q, size_d;
  logic aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic irdy_q, irdy_d, lrdy_q, lrdy_d, wrdy_q, wrdy_d;
  logic bus_err_q, bus_err_d;
  logic store, gnt_i, gnt_d, aw_ok, w_ok;
  // the LSU sees lsu_wready one cycle late, so its store is still visible during the pulse
  assign store = lsu_awvalid & lsu_wvalid & ~wrdy_q;
  ysyx_mem_arb_rr u_rr (
    .req_i (ifu_arvalid),
    .req_d (store | (lsu_arvalid & ~wrdy_q)),
    .last_d(last_d_q),
    .gnt_i (gnt_i),
    .gnt_d (gnt_d)
  );
  assign aw_ok = aw_done_q | (mem_awvalid & mem_awready);
  assign w_ok  = w_done_q | (mem_wvalid & mem_wready);
  always_comb begin
    st_d      = st_q;
    last_d_d  = last_d_q;
    addr_d    = addr_q;
    len_d     = len_q;
    size_d    = size_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    irdy_d    = st_q == I_AR & mem_arready;
    lrdy_d    = st_q == D_AR & mem_arready;
    wrdy_d    = st_q == D_B & mem_bvalid;
    bus_err_d = bus_err_q | (mem_rvalid & mem_rready & mem_rresp != AXI_RESP_OKAY)
                          | (mem_bvalid & mem_bready & mem_bresp != AXI_RESP_OKAY);
    case (st_q)
      IDLE: begin
        if (gnt_i) begin
          st_d     = I_AR;
          last_d_d = 1'b0;
          addr_d   = ifu_araddr;
          len_d    = 8'(L1I_BURST_LEN);
          size_d   = 3'd2;
        end else if (gnt_d) begin
          st_d     = store ? D_AW : D_AR;
          last_d_d = 1'b1;
          addr_d   = store ? lsu_awaddr : lsu_araddr;
          len_d    = 8'd0;
          size_d   = strb2size(store ? lsu_wstrb : lsu_rstrb);
          wdata_d  = lsu_wdata;
          wstrb_d  = lsu_wstrb[XLEN/8-1:0];
        end
      end
      I_AR:    st_d = mem_arready ? I_R : I_AR;
      I_R:     st_d = mem_rvalid & mem_rlast ? IDLE : I_R;
      D_AR:    st_d = mem_arready ? D_R : D_AR;
      D_R:     st_d = mem_rvalid & mem_rlast ? IDLE : D_R;
      D_AW:    st_d = aw_ok & w_ok ? D_B : D_AW;
      D_B:     st_d = mem_bvalid ? IDLE : D_B;
      default: st_d = IDLE;
    endcase
    aw_done_d = st_d == D_AW & aw_ok;
    w_done_d  = st_d == D_AW & w_ok;
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      st_q      <= IDLE;
      last_d_q  <= 1'b1;
      addr_q    <= '0;
      len_q     <= '0;
      size_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      irdy_q    <= 1'b0;
      lrdy_q    <= 1'b0;
      wrdy_q    <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      st_q      <= st_d;
      last_d_q  <= last_d_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      size_q    <= size_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      irdy_q    <= irdy_d;
      lrdy_q    <= lrdy_d;
      wrdy_q    <= wrdy_d;
      bus_err_q <= bus_err_d;
    end
  end
  assign mem_arvalid = st_q == I_AR | st_q == D_AR;
  assign mem_araddr  = addr_q;
  assign mem_arlen   = len_q;
  assign mem_arsize  = size_q;
  assign mem_rready  = st_q == I_R | st_q == D_R;
  assign ifu_rvalid  = st_q == I_R & mem_rvalid;
  assign ifu_rlast   = ifu_rvalid & mem_rlast;
  assign ifu_rdata   = st_q == I_R ? mem_rdata : '0;
  assign ifu_rready  = irdy_q;
  assign lsu_rvalid  = st_q == D_R & mem_rvalid & mem_rlast;
  assign lsu_rlast   = lsu_rvalid;
  assign lsu_rdata   = st_q == D_R ? mem_rdata : '0;
  assign lsu_rready  = lrdy_q;
  assign mem_awvalid = st_q == D_AW & ~aw_done_q;
  assign mem_awaddr  = addr_q;
  assign mem_awsize  = size_q;
  assign mem_wvalid  = st_q == D_AW & ~w_done_q;
  assign mem_wlast   = mem_wvalid;
  assign mem_wdata   = wdata_q;
  assign mem_wstrb   = wstrb_q;
  assign mem_bready  = st_q == D_B;
  assign lsu_wready  = wrdy_q;
  assign bus_err     = bus_err_q;
endmodule
